// File: rtl/axis_bit_unpacker_pkg.sv
// Shared definitions for the bit unpacker: width helpers and the stream state enum.
package axis_bit_unpacker_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned buf_width(input int unsigned iw, input int unsigned ow);
        return iw + ow;
    endfunction

    // Count must represent 0..BUF_W inclusive.
    function automatic int unsigned count_width(input int unsigned bw);
        return clog2(bw + 1);
    endfunction

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TAIL = 1'b1
    } state_e;

endpackage

// File: rtl/axis_bit_unpacker_extract.sv
// Combinational field extractor: takes the top len_i bits of a left-aligned
// buffer as a right-aligned field and returns the buffer shifted past them.
module bit_field_extract
    import axis_bit_unpacker_pkg::*;
#(
    parameter int unsigned BUF_W = 64,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned LEN_W = 6
) (
    input  logic [BUF_W-1:0] buf_i,
    input  logic [LEN_W-1:0] len_i,
    output logic [OUT_W-1:0] field_o,
    output logic [BUF_W-1:0] shifted_o
);

    localparam int unsigned SHW = clog2(BUF_W + 1);

    logic [SHW-1:0]   rsh;
    logic [BUF_W-1:0] aligned;

    always_comb begin
        rsh       = SHW'(BUF_W) - SHW'(len_i);
        aligned   = buf_i >> rsh;
        field_o   = aligned[OUT_W-1:0];
        shifted_o = buf_i << len_i;
    end

endmodule

// File: rtl/axis_bit_unpacker.sv
// Bitstream unpacker: consumes packed words and field lengths, emits each
// field MSB-first, right-aligned and zero-extended.
module axis_bit_unpacker
    import axis_bit_unpacker_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH  = 32,
    parameter int unsigned OUTPUT_WIDTH = 32,
    parameter int unsigned LENGTH_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INPUT_WIDTH-1:0]  input_data,
    input  logic                    input_valid,
    output logic                    input_ready,
    input  logic                    input_last,
    input  logic [LENGTH_WIDTH-1:0] length_data,
    input  logic                    length_valid,
    output logic                    length_ready,
    output logic [OUTPUT_WIDTH-1:0] output_data,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic                    output_last,
    output logic                    length_error
);

    localparam int unsigned BUF_W = buf_width(INPUT_WIDTH, OUTPUT_WIDTH);
    localparam int unsigned CW    = count_width(BUF_W);

    state_e                  state_q, state_d;
    logic [BUF_W-1:0]        buf_q, buf_d;
    logic [CW-1:0]           count_q, count_d;
    logic [OUTPUT_WIDTH-1:0] od_q, od_d;
    logic                    ov_q, ov_d;
    logic                    ol_q, ol_d;
    logic                    err_q, err_d;

    logic                    clamp;
    logic [LENGTH_WIDTH-1:0] le;
    logic [CW-1:0]           le_cnt;
    logic                    in_hs;
    logic                    len_hs;
    logic [OUTPUT_WIDTH-1:0] field;
    logic [BUF_W-1:0]        shifted;
    logic [BUF_W-1:0]        word_al;
    logic [BUF_W-1:0]        rem_buf;
    logic [CW-1:0]           rem_cnt;

    always_comb begin
        clamp  = length_data > LENGTH_WIDTH'(OUTPUT_WIDTH);
        le     = clamp ? LENGTH_WIDTH'(OUTPUT_WIDTH) : length_data;
        le_cnt = CW'(le);
    end

    assign input_ready  = (state_q == ST_RUN) && (count_q <= CW'(OUTPUT_WIDTH));
    assign length_ready = (!ov_q || output_ready) &&
                          ((count_q >= le_cnt) || (state_q == ST_TAIL));
    assign in_hs        = input_valid && input_ready;
    assign len_hs       = length_valid && length_ready;
    assign word_al      = {input_data, {OUTPUT_WIDTH{1'b0}}};

    bit_field_extract #(
        .BUF_W (BUF_W),
        .OUT_W (OUTPUT_WIDTH),
        .LEN_W (LENGTH_WIDTH)
    ) u_extract (
        .buf_i     (buf_q),
        .len_i     (le),
        .field_o   (field),
        .shifted_o (shifted)
    );

    // Bits below the valid region are kept zero at all times, so underflowing
    // fields pick up zero padding directly and appends can simply OR in.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        count_d = count_q;
        od_d    = od_q;
        ov_d    = ov_q;
        ol_d    = ol_q;
        err_d   = err_q;
        rem_buf = buf_q;
        rem_cnt = count_q;

        if (ov_q && output_ready) begin
            ov_d = 1'b0;
        end

        if (len_hs) begin
            od_d = field;
            ov_d = 1'b1;
            ol_d = 1'b0;
            if (clamp) begin
                err_d = 1'b1;
            end
            if ((state_q == ST_TAIL) && (le_cnt >= count_q)) begin
                ol_d    = 1'b1;
                rem_buf = '0;
                rem_cnt = '0;
                state_d = ST_RUN;
                if (le_cnt > count_q) begin
                    err_d = 1'b1;
                end
            end else begin
                rem_buf = shifted;
                rem_cnt = count_q - le_cnt;
            end
        end

        buf_d   = rem_buf;
        count_d = rem_cnt;

        if (in_hs) begin
            buf_d   = rem_buf | (word_al >> rem_cnt);
            count_d = rem_cnt + CW'(INPUT_WIDTH);
            if (input_last) begin
                state_d = ST_TAIL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            buf_q   <= '0;
            count_q <= '0;
            od_q    <= '0;
            ov_q    <= 1'b0;
            ol_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            count_q <= count_d;
            od_q    <= od_d;
            ov_q    <= ov_d;
            ol_q    <= ol_d;
            err_q   <= err_d;
        end
    end

    assign output_data  = od_q;
    assign output_valid = ov_q;
    assign output_last  = ol_q;
    assign length_error = err_q;

endmodule

// File: tb/tb_axis_bit_unpacker.sv
// Bench for axis_bit_unpacker: bit-queue reference model checked every cycle,
// directed streams with literal expectations, then randomized traffic.
module tb_axis_bit_unpacker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  input_data = '0;
    logic        input_valid = 1'b0;
    logic        input_ready;
    logic        input_last = 1'b0;
    logic [3:0]  length_data = '0;
    logic        length_valid = 1'b0;
    logic        length_ready;
    logic [11:0] output_data;
    logic        output_valid;
    logic        output_ready = 1'b1;
    logic        output_last;
    logic        length_error;

    always #5 clk = ~clk;

    axis_bit_unpacker #(
        .INPUT_WIDTH  (8),
        .OUTPUT_WIDTH (12),
        .LENGTH_WIDTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .input_data   (input_data),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_last   (input_last),
        .length_data  (length_data),
        .length_valid (length_valid),
        .length_ready (length_ready),
        .output_data  (output_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_last  (output_last),
        .length_error (length_error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stream bits as a queue, plus the output register contents.
    bit          mq[$];
    bit          m_tail = 1'b0;
    logic        m_ov = 1'b0;
    logic [11:0] m_od = '0;
    logic        m_ol = 1'b0;
    logic        m_err = 1'b0;
    bit          armed = 1'b0;

    logic [11:0] got_d[$];
    bit          got_l[$];
    bit          in_seen = 1'b0;
    bit          len_seen = 1'b0;

    logic [8:0]  wq[$];
    logic [3:0]  lq[$];
    int          ordy_mode = 1;
    bit          rnd_valid = 1'b0;

    always @(negedge clk) begin
        int          le;
        bit          eir, elr, ihs, lhs, lastf, uf, b;
        logic [11:0] v;
        le  = (length_data > 4'd12) ? 12 : int'(length_data);
        eir = !m_tail && (mq.size() <= 12);
        elr = (!m_ov || output_ready) && ((mq.size() >= le) || m_tail);
        if (armed) begin
            chk("output_valid", output_valid, m_ov);
            chk("output_data", output_data, m_od);
            chk("output_last", output_last, m_ol);
            chk("length_error", length_error, m_err);
            chk("input_ready", input_ready, eir);
            chk("length_ready", length_ready, elr);
        end
        ihs = !rst && input_valid && eir;
        lhs = !rst && length_valid && elr;
        in_seen  = ihs;
        len_seen = lhs;
        if (rst) begin
            mq.delete();
            m_tail = 1'b0;
            m_ov   = 1'b0;
            m_od   = '0;
            m_ol   = 1'b0;
            m_err  = 1'b0;
        end else begin
            if (m_ov && output_ready) begin
                got_d.push_back(output_data);
                got_l.push_back(output_last);
                m_ov = 1'b0;
            end
            if (lhs) begin
                lastf = m_tail && (mq.size() <= le);
                uf    = m_tail && (le > mq.size());
                v = '0;
                for (int i = 0; i < le; i++) begin
                    b = (mq.size() > 0) ? mq.pop_front() : 1'b0;
                    v = {v[10:0], b};
                end
                if (length_data > 4'd12 || uf) m_err = 1'b1;
                if (lastf) begin
                    mq.delete();
                    m_tail = 1'b0;
                end
                m_od = v;
                m_ol = lastf;
                m_ov = 1'b1;
            end
            if (ihs) begin
                for (int i = 7; i >= 0; i--) mq.push_back(input_data[i]);
                if (input_last) m_tail = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (in_seen && wq.size() > 0) void'(wq.pop_front());
        if (len_seen && lq.size() > 0) void'(lq.pop_front());
        if (wq.size() > 0 && (!rnd_valid || $urandom_range(3) != 0)) begin
            input_valid = 1'b1;
            {input_last, input_data} = wq[0];
        end else begin
            input_valid = 1'b0;
            input_last  = 1'b0;
            input_data  = '0;
        end
        if (lq.size() > 0 && (!rnd_valid || $urandom_range(3) != 0)) begin
            length_valid = 1'b1;
            length_data  = lq[0];
        end else begin
            length_valid = 1'b0;
            length_data  = '0;
        end
        case (ordy_mode)
            0:       output_ready = 1'b0;
            1:       output_ready = 1'b1;
            default: output_ready = ($urandom_range(1) == 1);
        endcase
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        wq.delete();
        lq.delete();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        got_d.delete();
        got_l.delete();
    endtask

    task automatic wait_fields(input int n, input int budget);
        int c;
        c = 0;
        while (got_d.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        chk("field_count", got_d.size(), n);
    endtask

    task automatic expect_field(input string name, input int i, input logic [11:0] d, input bit l);
        chk({name, "_data"}, (got_d.size() > i) ? 32'(got_d[i]) : 32'hDEAD_BEEF, 32'(d));
        chk({name, "_last"}, (got_l.size() > i) ? 32'(got_l[i]) : 32'hDEAD_BEEF, 32'(l));
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got %0d expected done", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        armed = 1'b1;
        chk("rst_output_valid", output_valid, 0);
        chk("rst_output_data", output_data, 0);
        chk("rst_output_last", output_last, 0);
        chk("rst_length_error", length_error, 0);
        rst = 1'b0;
        tick(1);

        // Nibble split
        got_d.delete(); got_l.delete();
        wq.push_back({1'b0, 8'hA5}); wq.push_back({1'b1, 8'h3C});
        for (int i = 0; i < 4; i++) lq.push_back(4'd4);
        wait_fields(4, 100);
        expect_field("nib0", 0, 12'hA, 0);
        expect_field("nib1", 1, 12'h5, 0);
        expect_field("nib2", 2, 12'h3, 0);
        expect_field("nib3", 3, 12'hC, 1);
        chk("nib_err", length_error, 0);

        // Spanning and zero-length fields
        got_d.delete(); got_l.delete();
        wq.push_back({1'b0, 8'hA5}); wq.push_back({1'b1, 8'h3C});
        lq.push_back(4'd12); lq.push_back(4'd0); lq.push_back(4'd4);
        wait_fields(3, 100);
        expect_field("span0", 0, 12'hA53, 0);
        expect_field("span1", 1, 12'h000, 0);
        expect_field("span2", 2, 12'h00C, 1);
        chk("span_err", length_error, 0);

        // Underflow pads with zeros and flags the error
        got_d.delete(); got_l.delete();
        wq.push_back({1'b1, 8'hF3});
        lq.push_back(4'd4); lq.push_back(4'd8);
        wait_fields(2, 100);
        expect_field("uf0", 0, 12'h00F, 0);
        expect_field("uf1", 1, 12'h030, 1);
        chk("uf_err", length_error, 1);
        wq.push_back({1'b1, 8'h81});
        lq.push_back(4'd8);
        wait_fields(3, 100);
        expect_field("uf2", 2, 12'h081, 1);
        chk("uf_err_sticky", length_error, 1);
        do_reset();
        chk("reset_clears_err", length_error, 0);

        // Clamp to OUTPUT_WIDTH
        wq.push_back({1'b0, 8'hAB}); wq.push_back({1'b0, 8'hCD});
        lq.push_back(4'd15); lq.push_back(4'd4);
        wait_fields(2, 100);
        expect_field("clamp0", 0, 12'hABC, 0);
        expect_field("clamp1", 1, 12'h00D, 0);
        chk("clamp_err", length_error, 1);
        do_reset();

        // Backpressure holds the pending field and stalls both inputs
        ordy_mode = 0;
        wq.push_back({1'b0, 8'h12}); wq.push_back({1'b0, 8'h34});
        wq.push_back({1'b0, 8'h56}); wq.push_back({1'b1, 8'h78});
        for (int i = 0; i < 8; i++) lq.push_back(4'd4);
        tick(10);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", output_valid, 1);
            chk("bp_data", output_data, 12'h001);
            chk("bp_len_ready", length_ready, 0);
            chk("bp_in_ready", input_ready, 0);
            tick(1);
        end
        ordy_mode = 1;
        wait_fields(8, 200);
        for (int i = 0; i < 8; i++) expect_field("bp", i, 12'(i + 1), i == 7);
        do_reset();

        // Reset mid-stream discards buffered bits and the pending output
        ordy_mode = 0;
        wq.push_back({1'b0, 8'hA5});
        lq.push_back(4'd4);
        tick(6);
        chk("mid_pending", output_valid, 1);
        do_reset();
        ordy_mode = 1;
        chk("mid_rst_valid", output_valid, 0);
        chk("mid_rst_data", output_data, 0);
        chk("mid_rst_last", output_last, 0);
        chk("mid_rst_err", length_error, 0);
        wq.push_back({1'b1, 8'h3C});
        lq.push_back(4'd8);
        wait_fields(1, 100);
        expect_field("mid", 0, 12'h03C, 1);

        // Randomized traffic with random valid gating and output backpressure
        rnd_valid = 1'b1;
        ordy_mode = 2;
        for (int i = 0; i < 80; i++)
            wq.push_back({($urandom_range(5) == 0) || (i == 79), 8'($urandom)});
        for (int i = 0; i < 220; i++)
            lq.push_back(4'($urandom_range(15)));
        tick(2500);
        rnd_valid = 1'b0;
        ordy_mode = 1;
        do_reset();
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
